// File: rtl/rca_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rca_pkg
//  Description : Shared types, constants and repair-select helpers for the
//                ripple-carry adder self-test and repair controller.
//  Revision    : 1.0  initial release
// ============================================================================
package rca_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TEST = 2'd1,
        EVAL = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int NVEC = 512;

    localparam logic [2:0] FAULT_FREE_IS = 3'b000;
    localparam logic [4:0] FAULT_FREE_CS = 5'b10000;
    localparam logic [3:0] FAULT_FREE_SS = 4'b0000;
    localparam logic [4:0] TEST_CS       = 5'b00000;

    typedef struct packed {
        logic [2:0] is_sel;
        logic [4:0] cs_sel;
        logic [3:0] ss_sel;
    } repair_t;

    // Everything at or above the faulty FA shifts up by one onto the spare.
    function automatic repair_t repair_cfg(input logic [1:0] k);
        repair_t r;
        r.is_sel = '0;
        r.cs_sel = '0;
        r.ss_sel = '0;
        for (int i = 0; i < 3; i++) begin
            if (i >= int'(k)) r.is_sel[i] = 1'b1;
        end
        for (int j = 0; j < 4; j++) begin
            if (j >= int'(k)) r.ss_sel[j] = 1'b1;
        end
        r.cs_sel[k] = 1'b1;
        return r;
    endfunction

    function automatic logic [1:0] lowest_idx(input logic [3:0] f);
        logic [1:0] idx;
        if (f[0])      idx = 2'd0;
        else if (f[1]) idx = 2'd1;
        else if (f[2]) idx = 2'd2;
        else if (f[3]) idx = 2'd3;
        else           idx = 2'd0;
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rca_fault_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : rca_fault_ctrl_if
//  Description : Control, adder-drive and adder-observation bundle of the
//                self-test/repair controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface rca_fault_ctrl_if;
    logic       start;
    logic [3:0] adder_sums;
    logic [3:0] adder_carrys;
    logic       test;
    logic [3:0] at;
    logic [3:0] bt;
    logic       cint;
    logic [2:0] is;
    logic [4:0] cs;
    logic [3:0] ss;
    logic       busy;
    logic       done;
    logic       fault_found;
    logic [1:0] fault_idx;

    modport master (
        input  start, adder_sums, adder_carrys,
        output test, at, bt, cint, is, cs, ss,
        output busy, done, fault_found, fault_idx
    );

    modport slave (
        output start, adder_sums, adder_carrys,
        input  test, at, bt, cint, is, cs, ss,
        input  busy, done, fault_found, fault_idx
    );
endinterface
`default_nettype wire

// File: rtl/rca_golden_chain.sv
`default_nettype none
// ============================================================================
//  Module      : rca_golden_chain
//  Description : Combinational 4-bit reference ripple adder exposing every
//                stage's sum and carry for comparison against the real adder.
//  Revision    : 1.0  initial release
// ============================================================================
module rca_golden_chain (
    input  logic [3:0] i_at,
    input  logic [3:0] i_bt,
    input  logic       i_cint,
    output logic [3:0] o_exp_s,
    output logic [3:0] o_exp_c
);

    logic w_carry;

    always_comb begin
        w_carry = i_cint;
        o_exp_s = '0;
        o_exp_c = '0;
        for (int i = 0; i < 4; i++) begin
            o_exp_s[i] = i_at[i] ^ i_bt[i] ^ w_carry;
            o_exp_c[i] = (i_at[i] & i_bt[i]) | (i_at[i] & w_carry) | (i_bt[i] & w_carry);
            w_carry    = o_exp_c[i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/rca_fault_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rca_fault_ctrl
//  Description : Exhaustive self-test of FA0..FA3 of the reconfigurable ripple
//                adder, locates a single faulty FA and holds its repair selects.
//  Revision    : 1.0  initial release
// ============================================================================
module rca_fault_ctrl
    import rca_pkg::*;
#(
    parameter int SETTLE = 1
)
(
    input  logic             clk,
    input  logic             rst,
    rca_fault_ctrl_if.master bus
);

    localparam logic [3:0] c_settle_last = 4'(SETTLE - 1);
    localparam logic [8:0] c_v_last      = 9'(NVEC - 1);

    state_t     r_state, w_state_nxt;
    logic [8:0] r_v, w_v_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [3:0] r_f, w_f_nxt;

    logic       r_test, w_test_nxt;
    logic [3:0] r_at, w_at_nxt;
    logic [3:0] r_bt, w_bt_nxt;
    logic       r_cint, w_cint_nxt;
    repair_t    r_sel, w_sel_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_done, w_done_nxt;
    logic       r_ff, w_ff_nxt;
    logic [1:0] r_idx, w_idx_nxt;

    logic [3:0] w_exp_s, w_exp_c, w_mis;

    // Reference is driven by the registered operands, i.e. what the adder sees.
    rca_golden_chain u_golden (
        .i_at    (r_at),
        .i_bt    (r_bt),
        .i_cint  (r_cint),
        .o_exp_s (w_exp_s),
        .o_exp_c (w_exp_c)
    );

    assign w_mis = (bus.adder_sums ^ w_exp_s) | (bus.adder_carrys ^ w_exp_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_v     <= '0;
            r_cnt   <= '0;
            r_f     <= '0;
            r_test  <= 1'b0;
            r_at    <= '0;
            r_bt    <= '0;
            r_cint  <= 1'b0;
            r_sel   <= '{is_sel: FAULT_FREE_IS, cs_sel: FAULT_FREE_CS, ss_sel: FAULT_FREE_SS};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ff    <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_v     <= w_v_nxt;
            r_cnt   <= w_cnt_nxt;
            r_f     <= w_f_nxt;
            r_test  <= w_test_nxt;
            r_at    <= w_at_nxt;
            r_bt    <= w_bt_nxt;
            r_cint  <= w_cint_nxt;
            r_sel   <= w_sel_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_ff    <= w_ff_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_v_nxt     = r_v;
        w_cnt_nxt   = r_cnt;
        w_f_nxt     = r_f;
        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_state_nxt = TEST;
                    w_v_nxt     = '0;
                    w_cnt_nxt   = '0;
                    w_f_nxt     = '0;
                end
            end
            TEST: begin
                // Compare only in the last hold cycle; exit on the final vector
                // instead of letting v wrap.
                if (r_cnt == c_settle_last) begin
                    w_f_nxt   = r_f | w_mis;
                    w_cnt_nxt = '0;
                    if (r_v == c_v_last) w_state_nxt = EVAL;
                    else                 w_v_nxt     = r_v + 9'd1;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            EVAL:    w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are computed for the upcoming state and registered.
    always_comb begin
        w_test_nxt = 1'b0;
        w_at_nxt   = '0;
        w_bt_nxt   = '0;
        w_cint_nxt = 1'b0;
        w_sel_nxt  = '{is_sel: FAULT_FREE_IS, cs_sel: FAULT_FREE_CS, ss_sel: FAULT_FREE_SS};
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        w_ff_nxt   = 1'b0;
        w_idx_nxt  = '0;
        case (w_state_nxt)
            TEST: begin
                w_test_nxt = 1'b1;
                w_at_nxt   = w_v_nxt[3:0];
                w_bt_nxt   = w_v_nxt[7:4];
                w_cint_nxt = w_v_nxt[8];
                w_sel_nxt  = '{is_sel: 3'b000, cs_sel: TEST_CS, ss_sel: 4'b0000};
                w_busy_nxt = 1'b1;
            end
            EVAL: begin
                w_busy_nxt = 1'b1;
            end
            DONE: begin
                w_done_nxt = 1'b1;
                w_ff_nxt   = |r_f;
                w_idx_nxt  = lowest_idx(r_f);
                if (|r_f) w_sel_nxt = repair_cfg(lowest_idx(r_f));
            end
            default: ;
        endcase
    end

    assign bus.test        = r_test;
    assign bus.at          = r_at;
    assign bus.bt          = r_bt;
    assign bus.cint        = r_cint;
    assign bus.is          = r_sel.is_sel;
    assign bus.cs          = r_sel.cs_sel;
    assign bus.ss          = r_sel.ss_sel;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.fault_found = r_ff;
    assign bus.fault_idx   = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_rca_fault_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rca_fault_ctrl
//  Description : Self-checking bench: fault-injecting adder model feeding the
//                controller, scoreboard of expected run results.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rca_fault_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rca_fault_ctrl_if b1 ();
    rca_fault_ctrl_if b2 ();

    rca_fault_ctrl #(.SETTLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
    rca_fault_ctrl #(.SETTLE(3)) u_dut2 (.clk(clk), .rst(rst), .bus(b2));

    int   flt_fa  = -1;
    logic flt_sum = 1'b0;
    logic flt_val = 1'b0;

    // Test-mode adder chain with one optional stuck-at on a sum or carry.
    function automatic logic [7:0] adder_model(input logic [3:0] a, input logic [3:0] b,
                                               input logic ci, input int ffa,
                                               input logic fsum, input logic fval);
        logic       c;
        logic [3:0] s, co;
        c  = ci;
        s  = '0;
        co = '0;
        for (int i = 0; i < 4; i++) begin
            s[i]  = a[i] ^ b[i] ^ c;
            co[i] = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
            if (i == ffa) begin
                if (fsum) s[i]  = fval;
                else      co[i] = fval;
            end
            c = co[i];
        end
        return {s, co};
    endfunction

    assign {b1.adder_sums, b1.adder_carrys} = adder_model(b1.at, b1.bt, b1.cint, flt_fa, flt_sum, flt_val);
    assign {b2.adder_sums, b2.adder_carrys} = adder_model(b2.at, b2.bt, b2.cint, -1, 1'b0, 1'b0);

    typedef struct {
        int         cyc;
        int         busy;
        logic       ff;
        logic [1:0] idx;
        logic [2:0] is_v;
        logic [4:0] cs_v;
        logic [3:0] ss_v;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    int   done_cyc, busy_cnt, vec_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is sampled at edge 1 of the count.
    task automatic pulse_and_run(output int dcyc, output int bcnt, output int verr);
        b1.start = 1'b1;
        dcyc = -1;
        bcnt = 0;
        verr = 0;
        for (int e = 1; e <= 2000; e++) begin
            @(negedge clk);
            b1.start = 1'b0;
            if (b1.busy) bcnt++;
            if (e <= 512) begin
                if ({b1.cint, b1.bt, b1.at} !== 9'(e - 1)) verr++;
                if (b1.test !== 1'b1) verr++;
            end
            if (b1.done) begin
                dcyc = e;
                break;
            end
        end
    endtask

    task automatic verify_run(input string tag);
        exp_t x;
        x = sb.pop_front();
        check({tag, "_done_cyc"}, done_cyc, x.cyc);
        check({tag, "_busy_cnt"}, busy_cnt, x.busy);
        check({tag, "_vectors"},  vec_err, 0);
        check({tag, "_ff"},       b1.fault_found, x.ff);
        if (x.ff) check({tag, "_idx"}, b1.fault_idx, x.idx);
        check({tag, "_is"},       b1.is, x.is_v);
        check({tag, "_cs"},       b1.cs, x.cs_v);
        check({tag, "_ss"},       b1.ss, x.ss_v);
        check({tag, "_test"},     {b1.test, b1.at, b1.bt, b1.cint}, 10'd0);
        check({tag, "_busy"},     b1.busy, 1'b0);
    endtask

    initial begin
        b1.start = 1'b0;
        b2.start = 1'b0;
        rst      = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_test",  b1.test, 1'b0);
        check("rst_opnd",  {b1.at, b1.bt, b1.cint}, 9'd0);
        check("rst_is",    b1.is, 3'b000);
        check("rst_cs",    b1.cs, 5'b10000);
        check("rst_ss",    b1.ss, 4'b0000);
        check("rst_stat",  {b1.busy, b1.done, b1.fault_found, b1.fault_idx}, 5'd0);
        rst = 1'b0;
        @(negedge clk);

        // fault-free
        sb.push_back('{514, 513, 1'b0, 2'd0, 3'b000, 5'b10000, 4'b0000});
        pulse_and_run(done_cyc, busy_cnt, vec_err);
        verify_run("clean");

        // FA2 sum stuck-at-0
        flt_fa = 2; flt_sum = 1'b1; flt_val = 1'b0;
        sb.push_back('{514, 513, 1'b1, 2'd2, 3'b100, 5'b00100, 4'b1100});
        pulse_and_run(done_cyc, busy_cnt, vec_err);
        verify_run("fa2_s0");

        // FA0 carry stuck-at-1: downstream FAs also mismatch
        flt_fa = 0; flt_sum = 1'b0; flt_val = 1'b1;
        sb.push_back('{514, 513, 1'b1, 2'd0, 3'b111, 5'b00001, 4'b1111});
        pulse_and_run(done_cyc, busy_cnt, vec_err);
        verify_run("fa0_c1");

        // FA3 carry stuck-at-0
        flt_fa = 3; flt_sum = 1'b0; flt_val = 1'b0;
        sb.push_back('{514, 513, 1'b1, 2'd3, 3'b000, 5'b01000, 4'b1000});
        pulse_and_run(done_cyc, busy_cnt, vec_err);
        verify_run("fa3_c0");

        // reset in the middle of a test run, then a clean restart
        flt_fa = -1;
        b1.start = 1'b1;
        for (int e = 1; e <= 100; e++) begin
            @(negedge clk);
            b1.start = 1'b0;
        end
        check("mid_busy_before_rst", b1.busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_test", b1.test, 1'b0);
        check("mid_rst_busy", b1.busy, 1'b0);
        check("mid_rst_cs",   b1.cs, 5'b10000);
        check("mid_rst_done", b1.done, 1'b0);
        @(negedge clk);
        sb.push_back('{514, 513, 1'b0, 2'd0, 3'b000, 5'b10000, 4'b0000});
        pulse_and_run(done_cyc, busy_cnt, vec_err);
        verify_run("restart");

        // SETTLE=3 instance, second start while busy must be ignored
        begin
            int d2   = -1;
            int bc2  = 0;
            int herr = 0;
            b2.start = 1'b1;
            for (int e = 1; e <= 4000; e++) begin
                @(negedge clk);
                b2.start = (e == 49) ? 1'b1 : 1'b0;
                if (b2.busy) bc2++;
                if (e <= 1536 && {b2.cint, b2.bt, b2.at} !== 9'((e - 1) / 3)) herr++;
                if (b2.done) begin
                    d2 = e;
                    break;
                end
            end
            check("s3_done_cyc", d2, 1538);
            check("s3_busy_cnt", bc2, 1537);
            check("s3_hold",     herr, 0);
            check("s3_ff",       b2.fault_found, 1'b0);
            check("s3_cs",       b2.cs, 5'b10000);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
